// File: rtl/uart_tx_fifo_drain_pkg.sv
// uart_tx_fifo_drain_pkg
//   Shared UART definitions: transmitter FSM state encoding, frame-length
//   constants and a helper returning the total frame length in bit clocks.
//   No ports (package).
package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Start + stop bits framing every word, plus the optional parity bit.
    localparam int unsigned FRAME_OVERHEAD_BITS = 2;
    localparam int unsigned PARITY_BITS         = 1;

    function automatic int unsigned frame_len(input int unsigned data_width,
                                              input logic        par_en);
        return FRAME_OVERHEAD_BITS + data_width + (par_en ? PARITY_BITS : 0);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if
//   Groups the FIFO read side, the frame configuration and the serial line
//   of the transmitter.
//   Signals:
//     i_EMPTY    FIFO empty flag              (FIFO -> tx)
//     i_RD_DATA  FIFO head word               (FIFO -> tx)
//     o_R_INC    FIFO pop strobe              (tx -> FIFO)
//     i_PAR_EN   append parity bit            (cfg -> tx)
//     i_PAR_TYP  0 = even, 1 = odd parity     (cfg -> tx)
//     o_TX       serial line, idle high       (tx -> line)
//     o_BUSY     frame in progress            (tx -> cfg)
//   Modports: slave = transmitter, master = FIFO/config/line side.
interface uart_tx_fifo_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_EMPTY;
    logic [DATA_WIDTH-1:0] i_RD_DATA;
    logic                  o_R_INC;
    logic                  i_PAR_EN;
    logic                  i_PAR_TYP;
    logic                  o_TX;
    logic                  o_BUSY;

    modport slave (
        input  i_EMPTY, i_RD_DATA, i_PAR_EN, i_PAR_TYP,
        output o_R_INC, o_TX, o_BUSY
    );

    modport master (
        output i_EMPTY, i_RD_DATA, i_PAR_EN, i_PAR_TYP,
        input  o_R_INC, o_TX, o_BUSY
    );
endinterface

// File: rtl/uart_tx_fifo_drain_parity.sv
// uart_parity_calc
//   Combinational parity generator shared by the UART transmit and receive
//   paths.
//   Ports:
//     data     word to protect
//     par_typ  0 = even parity, 1 = odd parity
//     parity   resulting parity bit
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);
    assign parity = (^data) ^ par_typ;
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//   Pops words from a same-clock FIFO and serializes them as UART frames,
//   one bit per i_CLK cycle: start, DATA_WIDTH data bits LSB first, optional
//   parity, stop. A non-empty FIFO in STOP is popped immediately so frames
//   run back to back.
//   Ports:
//     i_CLK  bit clock
//     i_RST  asynchronous active-high reset
//     bus    uart_tx_fifo_drain_if.slave (FIFO read side, config, serial line)
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    uart_tx_fifo_drain_if.slave   bus
);
    localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state, state_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q, shift_nx;
    logic                  par_en_q, par_bit_q, par_bit_calc;
    logic                  pop, tx_q, tx_next;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data    (bus.i_RD_DATA),
        .par_typ (bus.i_PAR_TYP),
        .parity  (par_bit_calc)
    );

    assign shift_nx = shift_q >> 1;

    always_comb begin
        // Gated by reset so no pop is issued while the FSM is held in IDLE.
        pop        = !i_RST && !bus.i_EMPTY &&
                     (state == ST_IDLE || state == ST_STOP);
        state_next = state;
        case (state)
            ST_IDLE:   if (pop) state_next = ST_START;
            ST_START:  state_next = ST_DATA;
            ST_DATA:   if (bit_cnt == LAST_BIT)
                           state_next = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: state_next = ST_STOP;
            ST_STOP:   state_next = pop ? ST_START : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase

        // o_TX is registered, so it is computed from the state being entered.
        // Leaving START shows bit 0 of the freshly loaded word; within DATA the
        // register shifts each cycle, so the next bit is the post-shift LSB.
        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = (state == ST_START) ? shift_q[0] : shift_nx[0];
            ST_PARITY: tx_next = par_bit_q;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= ST_IDLE;
            tx_q  <= 1'b1;
        end else begin
            state <= state_next;
            tx_q  <= tx_next;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            if (pop) begin
                shift_q   <= bus.i_RD_DATA;
                par_en_q  <= bus.i_PAR_EN;
                par_bit_q <= par_bit_calc;
            end else if (state == ST_DATA) begin
                shift_q   <= shift_nx;
            end

            if (state == ST_START)
                bit_cnt <= '0;
            else if (state == ST_DATA)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign bus.o_R_INC = pop;
    assign bus.o_TX    = tx_q;
    assign bus.o_BUSY  = (state != ST_IDLE);

endmodule

// File: doc/uart_tx_fifo_drain.md
UART_TX_FIFO_DRAIN -- requirements
Module: uart_tx_fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the FIFO read data and of the serialized payload.
REQ-002 SHALL have port i_CLK, input, 1: the single clock, equal to the transmit bit clock, so one bit is sent per cycle.
REQ-003 SHALL have port i_RST, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port i_EMPTY, input, 1: FIFO read-side empty flag.
REQ-005 SHALL have port i_RD_DATA, input, DATA_WIDTH: FIFO head word, valid whenever i_EMPTY=0.
REQ-006 SHALL have port o_R_INC, output, 1: FIFO pop strobe; the FIFO advances at the rising edge where it is high.
REQ-007 SHALL have port i_PAR_EN, input, 1: 1 = append a parity bit.
REQ-008 SHALL have port i_PAR_TYP, input, 1: 0 = even parity, 1 = odd parity.
REQ-009 SHALL have port o_TX, output, 1: serial line, idle high.
REQ-010 SHALL have port o_BUSY, output, 1: high while a frame is on the line.

Function
REQ-011 SHALL implement the FSM IDLE -> START -> DATA -> (PARITY if latched PAR_EN) -> STOP, with one cycle in each state except DATA, which lasts DATA_WIDTH cycles.
REQ-012 SHALL drive o_R_INC combinationally high only in IDLE or STOP, and only when i_EMPTY=0.
REQ-013 SHALL never assert o_R_INC while i_EMPTY=1 and SHALL never hold it high for two consecutive cycles.
REQ-014 SHALL, on the edge where o_R_INC=1, capture i_RD_DATA, i_PAR_EN and i_PAR_TYP into internal registers, and SHALL enter START.
REQ-015 SHALL ignore changes to i_PAR_EN and i_PAR_TYP between pops.
REQ-016 SHALL make o_TX a registered output with these values: 1 in IDLE, 0 in START, data bits LSB first in DATA, the parity bit in PARITY, 1 in STOP.
REQ-017 SHALL compute the parity bit as the XOR of the latched data for even parity and its complement for odd parity.
REQ-018 SHALL put the first start bit on o_TX one cycle after the pop edge.
REQ-019 SHALL make the frame length 1+DATA_WIDTH+1 cycles without parity and 1+DATA_WIDTH+2 cycles with parity.
REQ-020 SHALL use a bit counter of width clog2(DATA_WIDTH) that resets to 0 on entry to DATA and leaves DATA when it equals DATA_WIDTH-1.
REQ-021 SHALL, when i_EMPTY=0 in STOP, pop and go directly to START, so back-to-back frames have no idle gap.
REQ-022 SHALL, when i_EMPTY=1 in STOP, go to IDLE.
REQ-023 SHALL, when i_EMPTY=1 in IDLE, stay in IDLE with o_TX=1 and o_R_INC=0.
REQ-024 SHALL hold o_BUSY high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-025 SHALL NOT sample i_EMPTY or i_RD_DATA in START, DATA or PARITY.

Reset
REQ-026 SHALL, while i_RST=1, force state to IDLE, o_TX=1, o_BUSY=0, o_R_INC=0, bit counter=0, and data and parity registers to 0.
REQ-027 SHALL, on reset mid-frame, raise o_TX to 1 asynchronously and discard the popped word with no re-pop.
REQ-028 SHALL make the first pop after reset release happen no earlier than the first rising edge with i_RST=0.

Structure
REQ-029 SHALL place the FSM state encoding (3-bit localparams IDLE/START/DATA/PARITY/STOP) and the frame-length constants in the shared UART package.
REQ-030 SHALL implement parity in one sub-module, uart_parity_calc (inputs: data and type; output: 1-bit parity), reused by the receive side.
REQ-031 SHALL keep the shift register and FSM in this module, with no second clock and no synchronizers, since the FIFO read side already lives in the i_CLK domain.

Verification
REQ-032 SHALL cover single word 0xA5, PAR_EN=0: o_TX = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; o_R_INC high for exactly 1 cycle; o_BUSY high for 10 cycles.
REQ-033 SHALL cover 0xA5 with PAR_EN=1, PAR_TYP=0, then again with PAR_TYP=1: the parity bit is 0 and then 1; frame length 11 cycles each.
REQ-034 SHALL cover a FIFO preloaded with 10,20,80,30: four frames back to back with no idle cycle, decoded payloads 0x0A, 0x14, 0x50, 0x1E in order, then IDLE with o_TX=1.
REQ-035 SHALL cover i_EMPTY held at 1 for 50 cycles: o_R_INC never asserted, o_TX constantly 1, o_BUSY=0.
REQ-036 SHALL cover i_RST pulsed during data bit 3 of frame 0x3C: o_TX goes to 1 within the same cycle; after release with FIFO still holding 0x55, the next frame carries 0x55 and 0x3C is not resent.
REQ-037 SHALL cover i_PAR_TYP toggled mid-frame: the transmitted parity matches the value latched at pop.
